// File: rtl/sc_obc_mem_tester_pkg.sv
// Shared types, constants and pattern arithmetic for the SC-OBC memory test engine.
package sc_obc_mem_tester_pkg;

  typedef enum logic [1:0] {
    MODE_FILL           = 2'd0,
    MODE_CHECK          = 2'd1,
    MODE_FILL_CHECK     = 2'd2,
    MODE_FILL_CHECK_ALT = 2'd3
  } mode_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_FIN   = 3'd4
  } state_t;

  localparam logic [31:0] LANE_STEP = 32'h0101_0101;

  // Lane k of word idx; all arithmetic wraps mod 2^32.
  function automatic logic [31:0] pattern(input logic [31:0] seed,
                                          input logic [31:0] idx,
                                          input logic [31:0] lane);
    return seed + idx + lane * LANE_STEP;
  endfunction

endpackage

// File: rtl/sc_obc_mem_pattern.sv
// Combinational pattern generator: expands (seed, word index) into one DATA_W test word.
module sc_obc_mem_pattern
  import sc_obc_mem_tester_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int IDX_W  = 32
) (
  input  logic [31:0]       seed,
  input  logic [IDX_W-1:0]  index,
  output logic [DATA_W-1:0] word
);

  localparam int LANES = DATA_W / 32;

  logic [31:0] idx32;

  // Index is taken mod 2^32 regardless of the address width.
  assign idx32 = 32'(index);

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign word[32*k +: 32] = pattern(seed, idx32, 32'(k));
  end

endmodule

// File: rtl/sc_obc_mem_tester.sv
// Memory test engine: fills a word range with a seeded pattern, reads it back with bounded
// outstanding reads, and reports error count, first failing address and an error flag.
module sc_obc_mem_tester
  import sc_obc_mem_tester_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 64,
  parameter int MAX_OUT   = 8,
  parameter int ERR_CNT_W = 16
) (
  input  logic                 CLK,
  input  logic                 RSTN,
  input  logic                 START,
  input  logic [1:0]           MODE,
  input  logic [ADDR_W-1:0]    BASE_ADDR,
  input  logic [ADDR_W-1:0]    NUM_WORDS,
  input  logic [31:0]          SEED,
  output logic                 REQ_VALID,
  input  logic                 REQ_READY,
  output logic                 REQ_WE,
  output logic [ADDR_W-1:0]    REQ_ADDR,
  output logic [DATA_W-1:0]    REQ_WDATA,
  input  logic                 RSP_VALID,
  input  logic [DATA_W-1:0]    RSP_RDATA,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [ERR_CNT_W-1:0] ERR_COUNT,
  output logic [ADDR_W-1:0]    FIRST_ERR_ADDR,
  output logic                 ERR_FLAG
);

  localparam int                OUT_W     = $clog2(MAX_OUT + 1);
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(DATA_W / 8);
  localparam logic [ADDR_W-1:0] IDX_ONE   = ADDR_W'(1);
  localparam logic [OUT_W-1:0]  OUT_LIMIT = OUT_W'(MAX_OUT);
  localparam logic [OUT_W-1:0]  OUT_ONE   = OUT_W'(1);

  state_t state, state_nxt;

  mode_t             mode_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] num_q;
  logic [31:0]       seed_q;

  // Request side: index and byte address of the next request.
  logic [ADDR_W-1:0] req_idx;
  logic [ADDR_W-1:0] req_addr;

  // Response side: index and byte address of the next expected response.
  logic [ADDR_W-1:0] rsp_idx;
  logic [ADDR_W-1:0] rsp_addr;
  logic [OUT_W-1:0]  outstanding;

  // Registered compare stage.
  logic              cmp_valid;
  logic              cmp_bad;
  logic [ADDR_W-1:0] cmp_addr;

  logic [ERR_CNT_W-1:0] err_count;
  logic [ADDR_W-1:0]    first_err_addr;
  logic                 err_flag;

  logic [DATA_W-1:0] wr_word;
  logic [DATA_W-1:0] exp_word;

  logic run_start;
  logic req_fire;
  logic rd_fire;
  logic rsp_take;
  logic last_req;

  sc_obc_mem_pattern #(
    .DATA_W (DATA_W),
    .IDX_W  (ADDR_W)
  ) u_wr_pattern (
    .seed  (seed_q),
    .index (req_idx),
    .word  (wr_word)
  );

  sc_obc_mem_pattern #(
    .DATA_W (DATA_W),
    .IDX_W  (ADDR_W)
  ) u_exp_pattern (
    .seed  (seed_q),
    .index (rsp_idx),
    .word  (exp_word)
  );

  assign run_start = (state == ST_IDLE) && START;
  assign req_fire  = REQ_VALID && REQ_READY;
  assign rd_fire   = req_fire && (state == ST_READ);
  assign last_req  = (req_idx == num_q - IDX_ONE);
  // Responses count only while a check is running and never beyond the last word.
  assign rsp_take  = RSP_VALID && ((state == ST_READ) || (state == ST_DRAIN)) && (rsp_idx != num_q);

  // Once raised in READ, REQ_VALID holds: outstanding can only fall while a read stalls.
  assign REQ_VALID = (state == ST_WRITE) || ((state == ST_READ) && (outstanding < OUT_LIMIT));
  assign REQ_WE    = (state == ST_WRITE);
  assign REQ_ADDR  = req_addr;
  assign REQ_WDATA = REQ_WE ? wr_word : '0;

  assign BUSY           = (state != ST_IDLE);
  assign DONE           = (state == ST_FIN);
  assign ERR_COUNT      = err_count;
  assign FIRST_ERR_ADDR = first_err_addr;
  assign ERR_FLAG       = err_flag;

  always_ff @(posedge CLK or negedge RSTN) begin
    // NOTE: non-blocking assignment so every flop samples values from before the edge.
    if (!RSTN) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (START) begin
          if (NUM_WORDS == '0)          state_nxt = ST_FIN;
          else if (MODE == MODE_CHECK)  state_nxt = ST_READ;
          else                          state_nxt = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (req_fire && last_req) state_nxt = (mode_q == MODE_FILL) ? ST_FIN : ST_READ;
      end
      ST_READ: begin
        if (req_fire && last_req) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Wait for the final compare to land in the error registers.
        if ((rsp_idx == num_q) && !cmp_valid) state_nxt = ST_FIN;
      end
      ST_FIN:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      mode_q   <= MODE_FILL;
      base_q   <= '0;
      num_q    <= '0;
      seed_q   <= '0;
      req_idx  <= '0;
      req_addr <= '0;
    end else if (run_start) begin
      mode_q   <= mode_t'(MODE);
      base_q   <= BASE_ADDR;
      num_q    <= NUM_WORDS;
      seed_q   <= SEED;
      req_idx  <= '0;
      req_addr <= BASE_ADDR;
    end else if (req_fire) begin
      // Wrapping back after the last write re-arms the index for the read pass.
      if (last_req) begin
        req_idx  <= '0;
        req_addr <= base_q;
      end else begin
        req_idx  <= req_idx + IDX_ONE;
        req_addr <= req_addr + ADDR_STEP;
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      outstanding <= '0;
    end else if (run_start) begin
      outstanding <= '0;
    end else begin
      case ({rd_fire, rsp_take})
        2'b10:   outstanding <= outstanding + OUT_ONE;
        2'b01:   outstanding <= outstanding - OUT_ONE;
        default: outstanding <= outstanding;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      rsp_idx   <= '0;
      rsp_addr  <= '0;
      cmp_valid <= 1'b0;
      cmp_bad   <= 1'b0;
      cmp_addr  <= '0;
    end else if (run_start) begin
      rsp_idx   <= '0;
      rsp_addr  <= BASE_ADDR;
      cmp_valid <= 1'b0;
      cmp_bad   <= 1'b0;
      cmp_addr  <= '0;
    end else begin
      cmp_valid <= rsp_take;
      if (rsp_take) begin
        cmp_bad  <= (RSP_RDATA != exp_word);
        cmp_addr <= rsp_addr;
        rsp_idx  <= rsp_idx + IDX_ONE;
        rsp_addr <= rsp_addr + ADDR_STEP;
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      err_count      <= '0;
      first_err_addr <= '0;
      err_flag       <= 1'b0;
    end else if (run_start) begin
      err_count      <= '0;
      first_err_addr <= '0;
      err_flag       <= 1'b0;
    end else if (cmp_valid && cmp_bad) begin
      if (err_count != '1) err_count <= err_count + ERR_CNT_W'(1);
      if (!err_flag) begin
        err_flag       <= 1'b1;
        first_err_addr <= cmp_addr;
      end
    end
  end

endmodule

// File: tb/tb_sc_obc_mem_tester.sv
// Directed bench for sc_obc_mem_tester with an in-order, fixed-latency memory model.
module tb_sc_obc_mem_tester;

  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 64;
  localparam int MAX_OUT   = 4;
  localparam int ERR_CNT_W = 2;

  logic                 clk;
  logic                 rst_n;
  logic                 start;
  logic [1:0]           mode;
  logic [ADDR_W-1:0]    base_addr;
  logic [ADDR_W-1:0]    num_words;
  logic [31:0]          seed;
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_we;
  logic [ADDR_W-1:0]    req_addr;
  logic [DATA_W-1:0]    req_wdata;
  logic                 rsp_valid;
  logic [DATA_W-1:0]    rsp_rdata;
  logic                 busy;
  logic                 done;
  logic [ERR_CNT_W-1:0] err_count;
  logic [ADDR_W-1:0]    first_err_addr;
  logic                 err_flag;

  int checks   = 0;
  int failures = 0;

  sc_obc_mem_tester #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .MAX_OUT   (MAX_OUT),
    .ERR_CNT_W (ERR_CNT_W)
  ) dut (
    .CLK            (clk),
    .RSTN           (rst_n),
    .START          (start),
    .MODE           (mode),
    .BASE_ADDR      (base_addr),
    .NUM_WORDS      (num_words),
    .SEED           (seed),
    .REQ_VALID      (req_valid),
    .REQ_READY      (req_ready),
    .REQ_WE         (req_we),
    .REQ_ADDR       (req_addr),
    .REQ_WDATA      (req_wdata),
    .RSP_VALID      (rsp_valid),
    .RSP_RDATA      (rsp_rdata),
    .BUSY           (busy),
    .DONE           (done),
    .ERR_COUNT      (err_count),
    .FIRST_ERR_ADDR (first_err_addr),
    .ERR_FLAG       (err_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  typedef struct {
    int          due;
    logic [63:0] data;
  } rsp_t;

  logic [63:0] mem [logic [31:0]];
  bit          corrupt_map [logic [31:0]];
  rsp_t        rq [$];
  logic [31:0] wr_log [$];
  logic [63:0] wd_log [$];
  logic [31:0] rd_log [$];

  int lat         = 1;
  bit rand_ready  = 1'b0;
  bit corrupt_all = 1'b0;
  int cyc         = 0;
  int out_now     = 0;
  int out_max     = 0;
  int stall_err   = 0;
  int req_seen    = 0;
  int done_cnt    = 0;

  initial begin
    logic        stalled;
    logic        st_we;
    logic [31:0] st_addr;
    logic [63:0] st_wdata;
    logic [63:0] d;
    stalled   = 1'b0;
    st_we     = 1'b0;
    st_addr   = '0;
    st_wdata  = '0;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_rdata = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (stalled && rst_n) begin
        if (!(req_valid && req_we == st_we && req_addr == st_addr && req_wdata == st_wdata))
          stall_err++;
      end
      if (req_valid) req_seen++;
      if (done) done_cnt++;
      req_ready = rand_ready ? ($urandom_range(3) != 0) : 1'b1;
      stalled   = req_valid && !req_ready && rst_n;
      st_we     = req_we;
      st_addr   = req_addr;
      st_wdata  = req_wdata;
      if (req_valid && req_ready && req_we) begin
        mem[req_addr] = req_wdata;
        wr_log.push_back(req_addr);
        wd_log.push_back(req_wdata);
      end
      if (req_valid && req_ready && !req_we) begin
        d = mem.exists(req_addr) ? mem[req_addr] : 64'h0;
        if (corrupt_all || corrupt_map.exists(req_addr)) d = d ^ 64'h8;
        rd_log.push_back(req_addr);
        rq.push_back('{cyc + lat, d});
        out_now++;
      end
      rsp_valid = 1'b0;
      rsp_rdata = '0;
      if (rq.size() > 0 && rq[0].due == cyc) begin
        rsp_valid = 1'b1;
        rsp_rdata = rq[0].data;
        void'(rq.pop_front());
        out_now--;
      end
      if (out_now > out_max) out_max = out_now;
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Starts a run, waits (bounded) for DONE, returns the edge count from the START edge.
  task automatic run(input string tag, input logic [1:0] m, input logic [31:0] b,
                     input logic [31:0] n, input logic [31:0] s, output int edges);
    wr_log.delete();
    wd_log.delete();
    rd_log.delete();
    out_max   = 0;
    stall_err = 0;
    req_seen  = 0;
    done_cnt  = 0;
    mode      = m;
    base_addr = b;
    num_words = n;
    seed      = s;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    edges = 1;
    check({tag, "_busy_start"}, busy, 1);
    while (!done && edges < 3000) begin
      @(posedge clk);
      #1;
      edges++;
    end
    check({tag, "_done_seen"}, done, 1);
    check({tag, "_busy_fin"}, busy, 1);
    @(posedge clk);
    #1;
    check({tag, "_busy_after"}, {busy, done}, 0);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_done_pulses"}, done_cnt, 1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_req_valid"}, req_valid, 0);
    check({tag, "_req_we"}, req_we, 0);
    check({tag, "_req_addr"}, req_addr, 0);
    check({tag, "_req_wdata"}, req_wdata, 0);
    check({tag, "_busy_done"}, {busy, done}, 0);
    check({tag, "_err"}, {err_flag, err_count, first_err_addr}, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int edges;
    int n;
    int bad;
    logic [31:0] a;

    rst_n     = 1'b0;
    start     = 1'b0;
    mode      = 2'd0;
    base_addr = '0;
    num_words = '0;
    seed      = '0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: clean fill-then-check, 1-cycle response latency.
    lat = 1;
    run("t1", 2'd2, 32'h1000, 32'd16, 32'hA5A5_0000, edges);
    check("t1_wr_cnt", wr_log.size(), 16);
    check("t1_rd_cnt", rd_log.size(), 16);
    if (wr_log.size() == 16 && rd_log.size() == 16) begin
      check("t1_wr0_addr", wr_log[0], 32'h1000);
      check("t1_wr0_data", wd_log[0], 64'hA6A6_0101_A5A5_0000);
      check("t1_wr15_addr", wr_log[15], 32'h1078);
      check("t1_wr15_data", wd_log[15], 64'hA6A6_0110_A5A5_000F);
      check("t1_rd15_addr", rd_log[15], 32'h1078);
    end
    check("t1_err", {err_flag, err_count, first_err_addr}, 0);

    // 2: bit 3 of words 5 and 9 corrupted on read.
    corrupt_map[32'h1028] = 1'b1;
    corrupt_map[32'h1048] = 1'b1;
    run("t2", 2'd2, 32'h1000, 32'd16, 32'hA5A5_0000, edges);
    check("t2_err_count", err_count, 2);
    check("t2_first_addr", first_err_addr, 32'h1028);
    check("t2_err_flag", err_flag, 1);
    corrupt_map.delete();
    repeat (4) @(negedge clk);
    check("t2_status_hold", {err_flag, err_count, first_err_addr}, {1'b1, 2'd2, 32'h1028});

    // 3: check-only with zero words; START also clears the previous errors.
    run("t3", 2'd1, 32'h1000, 32'd0, 32'h0, edges);
    check("t3_edges", edges, 1);
    check("t3_no_req", req_seen, 0);
    check("t3_err_cleared", {err_flag, err_count, first_err_addr}, 0);

    // 4: latency 10, random ready, 64 words; outstanding bounded by MAX_OUT.
    lat        = 10;
    rand_ready = 1'b1;
    run("t4", 2'd2, 32'h2000, 32'd64, 32'h1234_5678, edges);
    rand_ready = 1'b0;
    check("t4_out_max", out_max, 4);
    check("t4_stall_err", stall_err, 0);
    check("t4_rd_cnt", rd_log.size(), 64);
    bad = 0;
    for (int i = 0; i < rd_log.size(); i++) begin
      a = 32'h2000 + 32'(i * 8);
      if (rd_log[i] != a) bad++;
    end
    check("t4_rd_order", bad, 0);
    check("t4_err", {err_flag, err_count}, 0);

    // 5: address wrap, fill only; seed chosen so lane 0 wraps on word 1.
    lat = 1;
    run("t5", 2'd0, 32'hFFFF_FFF0, 32'd4, 32'hFFFF_FFFF, edges);
    check("t5_wr_cnt", wr_log.size(), 4);
    check("t5_rd_cnt", rd_log.size(), 0);
    if (wr_log.size() == 4) begin
      check("t5_addr0", wr_log[0], 32'hFFFF_FFF0);
      check("t5_addr1", wr_log[1], 32'hFFFF_FFF8);
      check("t5_addr2", wr_log[2], 32'h0000_0000);
      check("t5_addr3", wr_log[3], 32'h0000_0008);
      check("t5_data1", wd_log[1], 64'h0101_0101_0000_0000);
    end

    // 6: zero-latency memory, MODE 3 behaves as MODE 2; DONE at START + 2N + 3.
    lat = 0;
    run("t6", 2'd3, 32'h5000, 32'd4, 32'h0000_0100, edges);
    check("t6_edges", edges, 11);
    check("t6_rd_cnt", rd_log.size(), 4);
    check("t6_err", {err_flag, err_count}, 0);

    // 7: every word corrupted, 2-bit counter saturates.
    lat         = 1;
    corrupt_all = 1'b1;
    run("t7", 2'd2, 32'h3000, 32'd8, 32'hDEAD_0000, edges);
    corrupt_all = 1'b0;
    check("t7_err_count_sat", err_count, 3);
    check("t7_first_addr", first_err_addr, 32'h3000);
    check("t7_err_flag", err_flag, 1);

    // 8: reset mid-READ, stale responses ignored, then a clean run.
    lat         = 3;
    corrupt_all = 1'b1;
    mode        = 2'd1;
    base_addr   = 32'h1000;
    num_words   = 32'd32;
    seed        = 32'h0;
    start       = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    while (!err_flag && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("t8_err_before_rst", err_flag, 1);
    check("t8_mid_read", {busy, req_we}, 2'b10);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("t8_rst");
    @(negedge clk);
    rst_n       = 1'b1;
    corrupt_all = 1'b0;
    repeat (15) @(negedge clk);
    check("t8_stale_ignored", {busy, err_flag, err_count, first_err_addr}, 0);
    lat = 1;
    run("t8_clean", 2'd2, 32'h4000, 32'd8, 32'h7777_0000, edges);
    check("t8_clean_err", {err_flag, err_count, first_err_addr}, 0);
    check("t8_clean_rd_cnt", rd_log.size(), 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sc_obc_mem_tester.md
# sc_obc_mem_tester

Parametrised memory test engine for the SC-OBC Versal design. It sits in the PL beside the PS block design and drives a simple valid/ready memory port bridged into the DDR4 controller. It fills an address range with a deterministic pattern and reads it back with up to `MAX_OUT` reads in flight. Error counts and the first failing address are reported for bring-up and in-orbit DDR health checks.

## Interface
- `ADDR_W`, 32: byte-address width.
- `DATA_W`, 64: data word width; must be a multiple of 32, 32–512.
- `MAX_OUT`, 8: maximum outstanding reads, 1–64.
- `ERR_CNT_W`, 16: error counter width.

Ports (one clock; reset is asynchronous and active-low):
- `CLK` in 1: clock.
- `RSTN` in 1: asynchronous active-low reset.
- `START` in 1: starts a run; sampled only in IDLE.
- `MODE` in 2: 0 = fill only, 1 = check only, 2 = fill then check, 3 = treated as 2.
- `BASE_ADDR` in ADDR_W: byte address of the first word.
- `NUM_WORDS` in ADDR_W: number of DATA_W words to test.
- `SEED` in 32: pattern seed.
- `REQ_VALID` out 1: memory request valid.
- `REQ_READY` in 1: memory request accepted.
- `REQ_WE` out 1: 1 = write, 0 = read.
- `REQ_ADDR` out ADDR_W: byte address of the request.
- `REQ_WDATA` out DATA_W: write data.
- `RSP_VALID` in 1: read data valid; responses return in order and cannot be back-pressured.
- `RSP_RDATA` in DATA_W: read data.
- `BUSY` out 1: high from START acceptance through the DONE cycle.
- `DONE` out 1: one-cycle pulse at the end of a run.
- `ERR_COUNT` out ERR_CNT_W: number of mismatching words; saturates at all-ones.
- `FIRST_ERR_ADDR` out ADDR_W: address of the first mismatching word.
- `ERR_FLAG` out 1: at least one mismatch in the current run.

## Operation
- States: IDLE, WRITE, READ, DRAIN, FIN.
- IDLE → WRITE (MODE 0/2/3) or READ (MODE 1) on START. START also latches the inputs and clears ERR_COUNT, FIRST_ERR_ADDR and ERR_FLAG.
- If NUM_WORDS == 0: IDLE → FIN directly.
- Word i has address `BASE_ADDR + i*(DATA_W/8)`, computed mod 2^ADDR_W, so the address wraps silently.
- Word i has pattern lane k (bits 32k+31:32k) equal to `SEED + i + k*32'h0101_0101`, mod 2^32.
- WRITE: issue one write per accepted handshake for i = 0..NUM_WORDS-1. After the last write is accepted:
  - MODE 0 → FIN.
  - Otherwise → READ, with the index reset to 0.
- READ: issue reads while `outstanding < MAX_OUT`, using the registered count. After the last read is accepted → DRAIN.
- The outstanding counter increments on a read accept and decrements on RSP_VALID. When both happen in the same cycle, it is unchanged.
- RSP_VALID compares RSP_RDATA against the pattern for the expected-response index j, which increments per response. On mismatch:
  - ERR_COUNT increments, saturating at all-ones.
  - If ERR_FLAG is 0, FIRST_ERR_ADDR is set to addr(j) and ERR_FLAG is set.
- DRAIN → FIN when the response for j = NUM_WORDS-1 has been compared.
- FIN → IDLE after one cycle.
- RSP_VALID is ignored outside READ and DRAIN. START is ignored when not in IDLE.
- Status outputs hold their values after DONE until the next accepted START.
- RSTN low mid-run aborts the run, drops REQ_VALID immediately and clears all state. Responses still in flight after reset are ignored.

## Timing
- Reset values: all outputs 0.
- START sampled at edge t → BUSY=1 and REQ_VALID=1 at t+1.
- Once REQ_VALID is asserted, REQ_WE, REQ_ADDR and REQ_WDATA stay stable until REQ_READY. The next request may be valid in the cycle after acceptance, giving at most one request per cycle.
- Compare is registered: RSP_VALID at edge t → ERR_COUNT/ERR_FLAG updated at t+1.
- DONE=1 and BUSY=1 in the FIN cycle; BUSY=0 the cycle after.
- With a zero-latency, always-ready memory, a MODE 2 run of N words has DONE at START + 2N + 3 cycles.

## Structure
- Package `sc_obc_mem_tester_pkg` contains:
  - the mode constants;
  - the state encoding;
  - lane constant `32'h0101_0101`;
  - function `pattern(seed, idx, lane)`.
- One combinational sub-module, `sc_obc_mem_pattern`, takes (SEED, index) and produces the DATA_W pattern word. It is instantiated twice: once for write data, once for the expected read data.
- FSM, counters and error capture live in the top `sc_obc_mem_tester`.

## Test plan
- MODE 2, BASE=0x1000, NUM_WORDS=16, SEED=0xA5A5_0000, DATA_W=64, memory always ready with 1-cycle response → 16 writes, then 16 reads; ERR_COUNT=0, ERR_FLAG=0, one DONE pulse.
- Same run with the model corrupting bit 3 of words 5 and 9 → ERR_COUNT=2, FIRST_ERR_ADDR=0x1028, ERR_FLAG=1.
- MODE 1, NUM_WORDS=0 → FIN the cycle after START, DONE pulse, no REQ_VALID ever asserted.
- MAX_OUT=4, response latency 10, random REQ_READY → outstanding never exceeds 4, REQ fields stable while stalled, all 64 words compared in order, ERR_COUNT=0.
- BASE=0xFFFF_FFF0, NUM_WORDS=4, DATA_W=64 → addresses 0xFFFF_FFF0, 0xFFFF_FFF8, 0x0, 0x8.
- ERR_CNT_W=2 with every word corrupted over 8 words → ERR_COUNT=3 (saturated). RSTN pulsed mid-READ → all outputs 0; a new run then completes cleanly.
